ddr2_mem_responder: RTL and testbench

// Single-port memory responder on ctrl_clk implementing the memory side of the ddr2_sys write/read waitrequest protocol.

---
 rtl/ddr2_mem_responder_if.sv | 45 ++++
 rtl/ddr2_mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_ddr2_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_mem_responder_if.sv
// ---------------------------------------------------------------------------
// ddr2_mem_responder_if
//
// Purpose: bundles the ddr2_sys-style write/read waitrequest bus, plus the
// responder's status outputs, so that the initiator and the memory responder
// can be wired together with a single connection.
//
// Signals:
//   write_addr, iData, write          initiator -> responder (write command)
//   write_waitrequest                 responder -> initiator
//   read_addr, read                   initiator -> responder (read command)
//   oData, read_waitrequest           responder -> initiator
//   wr_count, rd_count, addr_err      responder status
//
// Modports:
//   master : the initiator side (drives commands, observes responses)
//   slave  : the memory responder side
// ---------------------------------------------------------------------------
interface ddr2_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       write_addr;
    logic [DATA_W-1:0] iData;
    logic              write;
    logic              write_waitrequest;
    logic [31:0]       read_addr;
    logic              read;
    logic [DATA_W-1:0] oData;
    logic              read_waitrequest;
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;
    logic              addr_err;

    modport master (
        output write_addr, iData, write, read_addr, read,
        input  write_waitrequest, oData, read_waitrequest,
               wr_count, rd_count, addr_err
    );

    modport slave (
        input  write_addr, iData, write, read_addr, read,
        output write_waitrequest, oData, read_waitrequest,
               wr_count, rd_count, addr_err
    );
endinterface

// File: rtl/ddr2_mem_responder.sv
// ---------------------------------------------------------------------------
// ddr2_mem_responder
//
// Purpose: memory side of the ddr2_sys write/read waitrequest protocol, used
// in place of the real DRAM controller for simulation and bring-up of the
// camera -> DRAM -> display frame path. Commands are served one at a time
// from a word-addressed inferred RAM with programmable wait states; when a
// write and a read are requested together they are granted round-robin.
//
// Ports:
//   ctrl_clk  in   clock, all logic on the rising edge
//   reset     in   asynchronous, active-high
//   bus       slave modport of ddr2_mem_responder_if:
//     write_addr/read_addr  byte addresses, bits [1:0] ignored
//     iData                 write data, sampled on the completion cycle
//     write/read            requests, held by the initiator until completion
//     write_waitrequest     low only during the write completion cycle
//     read_waitrequest      low only during the read completion cycle
//     oData                 read data, valid on completion, held afterwards
//     wr_count/rd_count     completed-command counters (wrap at 2^16)
//     addr_err              sticky out-of-range flag, cleared by reset only
//
// Timing (command first sampled in IDLE at edge T):
//   write completes in cycle T+WR_LATENCY, read in cycle T+RD_LATENCY.
//   A completion cycle is always spent in WR_WAIT (cnt==0) or RD_DONE with
//   the registered waitrequest already low; the edge ending it commits the
//   command and returns the FSM to IDLE.
// ---------------------------------------------------------------------------
module ddr2_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 640,
    parameter int WR_LATENCY = 2,
    parameter int RD_LATENCY = 3
) (
    input  logic                 ctrl_clk,
    input  logic                 reset,
    ddr2_mem_responder_if.slave  bus
);

    localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
    localparam logic [7:0]  WR_CNT_INIT = 8'(WR_LATENCY - 1);
    localparam logic [7:0]  RD_CNT_INIT = 8'(RD_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_reg,      state_next;
    logic [7:0]         cnt_reg,        cnt_next;
    logic [IDX_W-1:0]   idx_reg,        idx_next;
    logic               oor_reg,        oor_next;
    logic               wr_wreq_reg,    wr_wreq_next;
    logic               rd_wreq_reg,    rd_wreq_next;
    logic [DATA_W-1:0]  odata_reg,      odata_next;
    logic [15:0]        wr_count_reg,   wr_count_next;
    logic [15:0]        rd_count_reg,   rd_count_next;
    logic               addr_err_reg,   addr_err_next;
    grant_t             last_grant_reg, last_grant_next;

    // RAM control
    logic               ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_q;
    logic [DATA_W-1:0]  ram [DEPTH];

    // Arbitration and address decode helpers
    logic               grant_wr;
    logic               grant_rd;
    logic               wr_addr_oor;
    logic               rd_addr_oor;

    // Byte-lane bits of the addresses are intentionally ignored.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{bus.write_addr[1:0], bus.read_addr[1:0]};

    // Range check uses the full word index so that large addresses never
    // alias onto a valid RAM word.
    assign wr_addr_oor = (bus.write_addr[31:2] >= DEPTH_WORDS);
    assign rd_addr_oor = (bus.read_addr[31:2]  >= DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        oor_next        = oor_reg;
        wr_wreq_next    = 1'b1;
        rd_wreq_next    = 1'b1;
        odata_next      = odata_reg;
        wr_count_next   = wr_count_reg;
        rd_count_next   = rd_count_reg;
        addr_err_next   = addr_err_reg;
        last_grant_next = last_grant_reg;
        ram_we          = 1'b0;
        ram_re          = 1'b0;

        // Write wins when it is alone, or when both are pending and the
        // previous grant went to a read.
        grant_wr = bus.write && (!bus.read || (last_grant_reg == GRANT_READ));
        grant_rd = bus.read && !grant_wr;

        unique case (state_reg)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR_WAIT;
                    cnt_next   = WR_CNT_INIT;
                    idx_next   = bus.write_addr[IDX_W+1:2];
                    oor_next   = wr_addr_oor;
                end else if (grant_rd) begin
                    state_next = RD_WAIT;
                    cnt_next   = RD_CNT_INIT;
                    idx_next   = bus.read_addr[IDX_W+1:2];
                    oor_next   = rd_addr_oor;
                end
            end

            WR_WAIT: begin
                if (!bus.write) begin
                    // Initiator withdrew: abandon without touching the RAM.
                    state_next = IDLE;
                end else if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else if (wr_wreq_reg) begin
                    // Count expired: open the completion cycle next.
                    wr_wreq_next = 1'b0;
                end else begin
                    // Completion cycle: commit the write at this edge.
                    ram_we          = !oor_reg;
                    addr_err_next   = addr_err_reg | oor_reg;
                    wr_count_next   = wr_count_reg + 16'd1;
                    last_grant_next = GRANT_WRITE;
                    state_next      = IDLE;
                end
            end

            RD_WAIT: begin
                if (!bus.read) begin
                    state_next = IDLE;
                end else if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    // Synchronous RAM: data appears one edge after the issue.
                    ram_re     = !oor_reg;
                    state_next = RD_DONE;
                end
            end

            RD_DONE: begin
                if (!bus.read) begin
                    state_next = IDLE;
                end else if (rd_wreq_reg) begin
                    // RAM output is valid now; present it with the handshake.
                    rd_wreq_next = 1'b0;
                    odata_next   = oor_reg ? '0 : ram_q;
                end else begin
                    addr_err_next   = addr_err_reg | oor_reg;
                    rd_count_next   = rd_count_reg + 16'd1;
                    last_grant_next = GRANT_READ;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            idx_reg        <= '0;
            oor_reg        <= 1'b0;
            wr_wreq_reg    <= 1'b1;
            rd_wreq_reg    <= 1'b1;
            odata_reg      <= '0;
            wr_count_reg   <= 16'd0;
            rd_count_reg   <= 16'd0;
            addr_err_reg   <= 1'b0;
            last_grant_reg <= GRANT_READ;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            oor_reg        <= oor_next;
            wr_wreq_reg    <= wr_wreq_next;
            rd_wreq_reg    <= rd_wreq_next;
            odata_reg      <= odata_next;
            wr_count_reg   <= wr_count_next;
            rd_count_reg   <= rd_count_next;
            addr_err_reg   <= addr_err_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Inferred single-port RAM with registered read. Contents survive
    // reset; the enables come from reset state, so an abandoned command
    // cannot write.
    // ------------------------------------------------------------------
    always_ff @(posedge ctrl_clk) begin
        if (ram_we) begin
            ram[idx_reg] <= bus.iData;
        end
        if (ram_re) begin
            ram_q <= ram[idx_reg];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.write_waitrequest = wr_wreq_reg;
    assign bus.read_waitrequest  = rd_wreq_reg;
    assign bus.oData             = odata_reg;
    assign bus.wr_count          = wr_count_reg;
    assign bus.rd_count          = rd_count_reg;
    assign bus.addr_err          = addr_err_reg;

endmodule

// File: tb/tb_ddr2_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ddr2_mem_responder
//
// Self-checking bench for ddr2_mem_responder. Expected values come from a
// word-array memory model, expected counters and the configured latencies.
// One line is printed per failed comparison plus a final summary line.
// ---------------------------------------------------------------------------
module tb_ddr2_mem_responder;

    localparam int WR_LAT = 2;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 640;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr2_mem_responder_if #(.DATA_W(32)) bus();

    ddr2_mem_responder #(
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .WR_LATENCY (WR_LAT),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .ctrl_clk (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [31:0] model_mem [DEPTH];
    int          exp_wr  = 0;
    int          exp_rd  = 0;
    bit          exp_err = 1'b0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        int          exp_wr_cnt;
        int          exp_rd_cnt;
        bit          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[31:2]);
        if (idx < DEPTH) return model_mem[idx];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        int idx;
        idx = int'(addr[31:2]);
        if (idx < DEPTH) model_mem[idx] = data;
        else             exp_err = 1'b1;
        exp_wr++;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
    endtask

    // Single write; the address is scrambled after the grant edge and the
    // data only becomes correct after it, so both latching rules are exercised.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        @(posedge clk); #1;
        bus.write_addr = addr;
        bus.iData      = ~data;
        bus.write      = 1'b1;
        @(posedge clk); #1;
        bus.write_addr = addr ^ 32'h40;
        bus.iData      = data;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.write_waitrequest) begin
                done = 1'b1;
                lat  = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("wr_handshake", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.write = 1'b0;
        if (done) model_write(addr, data);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        data = 32'hx;
        @(posedge clk); #1;
        bus.read_addr = addr;
        bus.read      = 1'b1;
        @(posedge clk); #1;
        bus.read_addr = addr ^ 32'h40;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.read_waitrequest) begin
                done = 1'b1;
                lat  = k;
                data = bus.oData;
                break;
            end
            @(posedge clk); #1;
        end
        check("rd_handshake", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.read = 1'b0;
        if (done) exp_rd++;
    endtask

    // Raise write and read in the same cycle; record each completion cycle
    // (relative to the first sampling edge) and drop each request after it.
    task automatic do_both(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                           output int wr_k, output int rd_k, output logic [31:0] rdata);
        wr_k  = -1;
        rd_k  = -1;
        rdata = 32'hx;
        @(posedge clk); #1;
        bus.write_addr = wa;
        bus.iData      = wd;
        bus.write      = 1'b1;
        bus.read_addr  = ra;
        bus.read       = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (wr_k >= 0) bus.write = 1'b0;
            if (rd_k >= 0) bus.read  = 1'b0;
            if (wr_k >= 0 && rd_k >= 0) break;
            @(negedge clk);
            if (bus.write && !bus.write_waitrequest) wr_k = k;
            if (bus.read && !bus.read_waitrequest) begin
                rd_k  = k;
                rdata = bus.oData;
            end
        end
        bus.write = 1'b0;
        bus.read  = 1'b0;
        if (wr_k >= 0) model_write(wa, wd);
        if (rd_k >= 0) exp_rd++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, wk, rk;
        logic [31:0] rdata, exp_d, addr, data;

        vecs[0] = '{1'b1, 32'h000, 32'hA5A5_0001, 32'h0,          1, 0, 1'b0};
        vecs[1] = '{1'b0, 32'h000, 32'h0,         32'hA5A5_0001, 1, 1, 1'b0};
        vecs[2] = '{1'b1, 32'h007, 32'h1234_5678, 32'h0,          2, 1, 1'b0};
        vecs[3] = '{1'b0, 32'h004, 32'h0,         32'h1234_5678, 2, 2, 1'b0};
        vecs[4] = '{1'b1, 32'h9FC, 32'hDEAD_BEEF, 32'h0,          3, 2, 1'b0};
        vecs[5] = '{1'b0, 32'h9FF, 32'h0,         32'hDEAD_BEEF, 3, 3, 1'b0};
        vecs[6] = '{1'b1, 32'hA00, 32'h0000_0055, 32'h0,          4, 3, 1'b1};
        vecs[7] = '{1'b0, 32'hA00, 32'h0,         32'h0,          4, 4, 1'b1};
        vecs[8] = '{1'b0, 32'h000, 32'h0,         32'hA5A5_0001, 4, 5, 1'b1};

        bus.write_addr = '0;
        bus.iData      = '0;
        bus.write      = 1'b0;
        bus.read_addr  = '0;
        bus.read       = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_waitreq", 32'(bus.write_waitrequest), 32'd1);
        check("rst_rd_waitreq", 32'(bus.read_waitrequest),  32'd1);
        check("rst_odata",      bus.oData,                  32'd0);
        check("rst_wr_count",   32'(bus.wr_count),          32'd0);
        check("rst_rd_count",   32'(bus.rd_count),          32'd0);
        check("rst_addr_err",   32'(bus.addr_err),          32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, lat);
                check($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'(WR_LAT));
            end else begin
                do_read(vecs[i].addr, rdata, lat);
                check($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'(RD_LAT));
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
            check($sformatf("vec%0d_wr_count", i), 32'(bus.wr_count), 32'(vecs[i].exp_wr_cnt));
            check($sformatf("vec%0d_rd_count", i), 32'(bus.rd_count), 32'(vecs[i].exp_rd_cnt));
            check($sformatf("vec%0d_addr_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_err));
        end

        // ---------------- RAM survives reset, then full fill ----------------
        apply_reset();
        do_read(32'h0, rdata, lat);
        check("rst_keeps_ram", rdata, 32'hA5A5_0001);
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(32'(i * 4), 32'(i), lat);
            check("fill_wr_lat", 32'(lat), 32'(WR_LAT));
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = model_read(32'(i * 4));
            do_read(32'(i * 4), rdata, lat);
            check($sformatf("fill_rd_%0d", i), rdata, exp_d);
        end
        check("fill_wr_count", 32'(bus.wr_count), 32'(exp_wr));
        check("fill_rd_count", 32'(bus.rd_count), 32'(exp_rd));

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 200; i++) begin
            addr = 32'($urandom_range(0, DEPTH + 19)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                do_write(addr, data, lat);
                check($sformatf("rnd%0d_wr_lat", i), 32'(lat), 32'(WR_LAT));
            end else begin
                exp_d = model_read(addr);
                do_read(addr, rdata, lat);
                check($sformatf("rnd%0d_rd_lat", i), 32'(lat), 32'(RD_LAT));
                check($sformatf("rnd%0d_rdata @%h", i, addr), rdata, exp_d);
            end
            check($sformatf("rnd%0d_addr_err", i), 32'(bus.addr_err), 32'(exp_err));
        end
        check("rnd_wr_count", 32'(bus.wr_count), 32'(exp_wr[15:0]));
        check("rnd_rd_count", 32'(bus.rd_count), 32'(exp_rd[15:0]));

        // ---------------- simultaneous requests, round-robin ----------------
        // Last completion was a read (or write); force a known history first.
        do_read(32'h0, rdata, lat);
        exp_d = model_read(32'h20);
        do_both(32'h10, 32'hCAFE_0010, 32'h20, wk, rk, rdata);
        check("both1_wr_first_lat", 32'(wk), 32'(WR_LAT));
        check("both1_rd_after_wr",  32'(rk > wk + RD_LAT), 32'd1);
        check("both1_rdata",        rdata, exp_d);
        check("both1_read_0x10",    model_read(32'h10), 32'hCAFE_0010);
        do_read(32'h10, rdata, lat);
        check("both1_wr_landed",    rdata, model_read(32'h10));

        do_write(32'h18, 32'h0000_1818, lat);
        exp_d = model_read(32'h24);
        do_both(32'h1C, 32'hCAFE_001C, 32'h24, wk, rk, rdata);
        check("both2_rd_first_lat", 32'(rk), 32'(RD_LAT));
        check("both2_wr_after_rd",  32'(wk > rk + WR_LAT), 32'd1);
        check("both2_rdata",        rdata, exp_d);
        do_read(32'h1C, rdata, lat);
        check("both2_wr_landed",    rdata, model_read(32'h1C));
        check("both_wr_count",      32'(bus.wr_count), 32'(exp_wr[15:0]));
        check("both_rd_count",      32'(bus.rd_count), 32'(exp_rd[15:0]));

        // ---------------- aborted write ----------------
        exp_d = model_read(32'h30);
        @(posedge clk); #1;
        bus.write_addr = 32'h30;
        bus.iData      = 32'h0000_0BAD;
        bus.write      = 1'b1;
        @(posedge clk);              // granted here
        @(negedge clk);
        check("abort_wreq_hi0", 32'(bus.write_waitrequest), 32'd1);
        @(posedge clk); #1;          // one cycle in WR_WAIT, then withdraw
        bus.write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_wreq_hi", 32'(bus.write_waitrequest), 32'd1);
        end
        check("abort_wr_count", 32'(bus.wr_count), 32'(exp_wr[15:0]));
        do_read(32'h30, rdata, lat);
        check("abort_ram_kept", rdata, exp_d);

        // ---------------- reset in the middle of a read ----------------
        do_write(32'h14, 32'h1234_5678, lat);
        do_read(32'h14, rdata, lat);
        check("pre_rst_rdata", rdata, 32'h1234_5678);
        @(posedge clk); #1;
        bus.read_addr = 32'h14;
        bus.read      = 1'b1;
        @(posedge clk);              // granted
        @(posedge clk); #2;
        check("pre_rst_odata_hold", bus.oData, 32'h1234_5678);
        rst = 1'b1;
        #1;
        check("midrst_rd_waitreq", 32'(bus.read_waitrequest),  32'd1);
        check("midrst_wr_waitreq", 32'(bus.write_waitrequest), 32'd1);
        check("midrst_odata",      bus.oData,                  32'd0);
        check("midrst_rd_count",   32'(bus.rd_count),          32'd0);
        check("midrst_addr_err",   32'(bus.addr_err),          32'd0);
        bus.read = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
        do_read(32'h14, rdata, lat);
        check("post_rst_rdata",    rdata, 32'h1234_5678);
        check("post_rst_rd_count", 32'(bus.rd_count), 32'(exp_rd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
